// File: rtl/pipe_ex.sv
// pipe_ex: execute stage with request/acknowledge handshakes on both sides.
// Accepts an operation from decode, computes the ALU result (single cycle, or
// 32-cycle iterative shift-add for MUL), then presents the result and the
// forwarded memory/writeback control to the memory-access stage.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   up_syn / up_ack     decode-side request (level) / acknowledge
//   down_syn / down_ack memory-side request / acknowledge
//   alu_op, op_a, op_b  operation code and operands
//   op_st               store data
//   id_rw_e, id_rw_len  memory command and length from decode
//   id_rd, id_wb_e      destination register and writeback enable
//   ex_ans, ex_din      result/address and store data to memory stage
//   rw_e, rw_len, rd, ex_wb_e  registered copies of the id_* controls
//   busy                high whenever the stage is not idle
module pipe_ex #(
  parameter int unsigned DATA_L = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up_syn,
  output logic              up_ack,
  output logic              down_syn,
  input  logic              down_ack,
  input  logic [3:0]        alu_op,
  input  logic [DATA_L-1:0] op_a,
  input  logic [DATA_L-1:0] op_b,
  input  logic [DATA_L-1:0] op_st,
  input  logic [1:0]        id_rw_e,
  input  logic [1:0]        id_rw_len,
  input  logic [4:0]        id_rd,
  input  logic              id_wb_e,
  output logic [DATA_L-1:0] ex_ans,
  output logic [DATA_L-1:0] ex_din,
  output logic [1:0]        rw_e,
  output logic [1:0]        rw_len,
  output logic [4:0]        rd,
  output logic              ex_wb_e,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DATA_L);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_L - 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_LUI  = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    SEND   = 2'd2,
    WAITLO = 2'd3
  } state_e;

  state_e state, state_nxt;
  logic   accept_c, mul_step_c, exec_done_c;

  // Operation captured at accept
  logic [3:0]        op_q;
  logic [DATA_L-1:0] a_q, b_q, st_q;
  logic [1:0]        rwe_q, rwl_q;
  logic [4:0]        rd_q;
  logic              wbe_q;

  // Iterative multiplier: multiplicand shifts left, multiplier shifts right
  logic [CNT_W-1:0]  mul_cnt;
  logic [DATA_L-1:0] mul_acc, mul_mcand, mul_mplier;
  logic [DATA_L-1:0] mul_sum_c;
  logic [DATA_L-1:0] alu_res_c, result_c;
  logic [CNT_W-1:0]  shamt_c;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and control strobes
  always_comb begin
    state_nxt   = state;
    accept_c    = 1'b0;
    mul_step_c  = 1'b0;
    exec_done_c = 1'b0;
    case (state)
      IDLE: begin
        if (up_syn && !up_ack) begin
          accept_c  = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (op_q == OP_MUL && mul_cnt != CNT_LAST) begin
          mul_step_c = 1'b1;
        end else begin
          exec_done_c = 1'b1;
          state_nxt   = SEND;
        end
      end
      SEND: begin
        if (down_ack) state_nxt = WAITLO;
      end
      WAITLO: begin
        if (!down_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Single-cycle ALU; reserved codes give zero
  always_comb begin
    shamt_c   = b_q[CNT_W-1:0];
    alu_res_c = '0;
    case (op_q)
      OP_ADD:  alu_res_c = a_q + b_q;
      OP_SUB:  alu_res_c = a_q - b_q;
      OP_AND:  alu_res_c = a_q & b_q;
      OP_OR:   alu_res_c = a_q | b_q;
      OP_XOR:  alu_res_c = a_q ^ b_q;
      OP_NOR:  alu_res_c = ~(a_q | b_q);
      OP_SLT:  alu_res_c = DATA_L'($signed(a_q) < $signed(b_q));
      OP_SLTU: alu_res_c = DATA_L'(a_q < b_q);
      OP_SLL:  alu_res_c = a_q << shamt_c;
      OP_SRL:  alu_res_c = a_q >> shamt_c;
      OP_SRA:  alu_res_c = DATA_L'($signed(a_q) >>> shamt_c);
      OP_LUI:  alu_res_c = DATA_L'({b_q[15:0], 16'h0000});
      default: alu_res_c = '0;
    endcase
  end

  // Last multiplier step folds into the result directly
  always_comb begin
    mul_sum_c = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
    result_c  = (op_q == OP_MUL) ? mul_sum_c : alu_res_c;
  end

  // Operand capture and multiplier iteration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      st_q       <= '0;
      rwe_q      <= '0;
      rwl_q      <= '0;
      rd_q       <= '0;
      wbe_q      <= 1'b0;
      mul_cnt    <= '0;
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
    end else if (accept_c) begin
      op_q       <= alu_op;
      a_q        <= op_a;
      b_q        <= op_b;
      st_q       <= op_st;
      rwe_q      <= id_rw_e;
      rwl_q      <= id_rw_len;
      rd_q       <= id_rd;
      wbe_q      <= id_wb_e;
      mul_cnt    <= '0;
      mul_acc    <= '0;
      mul_mcand  <= op_a;
      mul_mplier <= op_b;
    end else if (mul_step_c) begin
      mul_cnt    <= mul_cnt + CNT_W'(1);
      mul_acc    <= mul_sum_c;
      mul_mcand  <= mul_mcand << 1;
      mul_mplier <= mul_mplier >> 1;
    end
  end

  // Handshake and registered outputs; data holds outside completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_ack   <= 1'b0;
      down_syn <= 1'b0;
      busy     <= 1'b0;
      ex_ans   <= '0;
      ex_din   <= '0;
      rw_e     <= '0;
      rw_len   <= '0;
      rd       <= '0;
      ex_wb_e  <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      if (accept_c)     up_ack <= 1'b1;
      else if (!up_syn) up_ack <= 1'b0;
      if (exec_done_c) begin
        down_syn <= 1'b1;
        ex_ans   <= result_c;
        ex_din   <= st_q;
        rw_e     <= rwe_q;
        rw_len   <= rwl_q;
        rd       <= rd_q;
        ex_wb_e  <= wbe_q;
      end else if (state == SEND && down_ack) begin
        down_syn <= 1'b0;
      end
    end
  end

endmodule

// File: doc/pipe_ex.md
PIPE_EX -- requirements
Module: pipe_ex

Interface
REQ-001 Parameter DATA_L, default 32, datapath width; all behaviour below is stated for 32.
REQ-002 clk  in  1  single clock; all state changes on posedge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 up_syn  in  1  upstream (decode) request, level, held until up_ack seen.
REQ-005 up_ack  out  1  upstream acknowledge.
REQ-006 down_syn  out  1  downstream (memory-access stage) request.
REQ-007 down_ack  in  1  downstream acknowledge.
REQ-008 alu_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 LUI, 12 MUL; 13-15 reserved.
REQ-009 op_a, op_b  in  32 each  ALU operands.
REQ-010 op_st  in  32  store data.
REQ-011 id_rw_e, id_rw_len  in  2 each  memory command/length (00 none, 01 write, 10 read, 11 read-upper).
REQ-012 id_rd  in  5  destination register; id_wb_e  in  1  writeback enable.
REQ-013 ex_ans  out  32  ALU result / memory address.
REQ-014 ex_din  out  32  store data to memory stage.
REQ-015 rw_e, rw_len  out  2 each; rd  out  5; ex_wb_e  out  1  registered copies of the id_* inputs.
REQ-016 busy  out  1  high whenever state is not IDLE.

Function
REQ-017 States IDLE, EXEC, SEND, WAITLO, 2-bit encoded, registered.
REQ-018 Accept: at an edge with state IDLE, up_syn=1, up_ack=0 -> latch alu_op, op_a, op_b, op_st, id_* into internal registers; up_ack<=1; state<=EXEC.
REQ-019 up_ack SHALL clear on the first edge at which up_syn is sampled 0, in any state; no other event clears it except reset.
REQ-020 up_syn=1 while up_ack=1 or state!=IDLE SHALL be ignored (no second accept).
REQ-021 EXEC, single-cycle ops (0-11): on the next edge ex_ans<=result, ex_din<=op_st, rw_e/rw_len/rd/ex_wb_e<=latched values, down_syn<=1, state<=SEND; down_syn rises exactly 1 cycle after accept edge.
REQ-022 Arithmetic: ADD/SUB modulo 2^32, no overflow flag; SLT signed and SLTU unsigned compare give 32'd1/32'd0; shifts use op_b[4:0] of op_a; SRA sign-fills; LUI = {op_b[15:0],16'h0000}.
REQ-023 MUL: iterative shift-add, 5-bit counter, one multiplier bit (op_b LSB first) per EXEC cycle; ex_ans = low 32 bits of op_a*op_b; down_syn rises exactly 32 cycles after accept edge.
REQ-024 Reserved alu_op SHALL produce ex_ans=0 with single-cycle timing.
REQ-025 ex_ans selection is independent of rw_e; decode supplies ADD for load/store addresses.
REQ-026 SEND: all outputs except up_ack held stable; edge with down_ack=1 -> down_syn<=0, state<=WAITLO.
REQ-027 WAITLO: edge with down_ack=0 -> state<=IDLE; a new accept is possible from the following edge.
REQ-028 down_ack=1 outside SEND SHALL be ignored.
REQ-029 Data outputs SHALL hold last values in IDLE/WAITLO.

Reset
REQ-030 rst=1 forces immediately: state IDLE, up_ack=0, down_syn=0, busy=0, ex_ans=0, ex_din=0, rw_e=0, rw_len=0, rd=0, ex_wb_e=0, MUL counter and partial product 0.
REQ-031 Reset during EXEC (including mid-MUL) or SEND aborts the operation; no down_syn pulse follows release.
REQ-032 After release, first accept possible on the first edge with up_syn=1.

Verification
REQ-033 ADD 5+7, id_rw_e=00, rd=3, wb_e=1 -> down_syn 1 cycle after accept; ex_ans=12, rd=3, ex_wb_e=1; down_ack pulse -> down_syn clears, busy drops after down_ack low.
REQ-034 SUB 0-1 -> ex_ans=FFFFFFFF; SLT FFFFFFFF vs 1 -> 1; SLTU same -> 0; SRA 80000000 by 4 -> F8000000; LUI op_b=1234 -> 12340000.
REQ-035 MUL 0001_0001*0000_FFFF -> ex_ans=FFFF_FFFF, down_syn exactly 32 cycles after accept, busy high throughout.
REQ-036 Store: ADD op_a=100 op_b=4, op_st=DEADBEEF, id_rw_e=01, rw_len=2 -> ex_ans=104, ex_din=DEADBEEF, rw_e=01; outputs stable while down_ack withheld 10 cycles.
REQ-037 up_syn held high across completion -> exactly one accept; second accept only after up_syn low one edge then high.
REQ-038 rst asserted mid-MUL (cycle 10) -> all outputs 0 asynchronously, no down_syn after release; next ADD completes normally.
